// File: rtl/rf_dbg_pkg.sv
// Shared types for the register-file debug (SDU) path: widths, dump FSM states, stream beat.
// Latency/backpressure: not applicable (types and constants only).
package rf_dbg_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND,
        SUM,
        DONE
    } state_t;

    typedef struct packed {
        logic [RF_DATA_W-1:0] data;
        logic [RF_ADDR_W-1:0] idx;
        logic                 last;
    } beat_t;

endpackage

// File: rtl/rf_dump_reader_if.sv
// Dump reader bundle: command, register-file debug read port, output stream and status.
// Latency: none (wires only); backpressure via out_valid/out_ready.
interface rf_dump_reader_if
    import rf_dbg_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_dout;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;
    logic              busy;
    logic              done;
`ifdef RF_DUMP_CHECKSUM_EN
    logic              sum_beat;
`endif

    modport master (
        input  start, abort, first_addr, last_addr, rf_dout, out_ready,
        output rf_addr, out_valid, out_data, out_idx, out_last, busy, done
`ifdef RF_DUMP_CHECKSUM_EN
        , output sum_beat
`endif
    );

    modport slave (
        output start, abort, first_addr, last_addr, rf_dout, out_ready,
        input  rf_addr, out_valid, out_data, out_idx, out_last, busy, done
`ifdef RF_DUMP_CHECKSUM_EN
        , input sum_beat
`endif
    );

endinterface

// File: rtl/rf_dump_outreg.sv
// Valid/ready output holding register: load captures a beat, clear drops valid, else hold.
// Latency: 1 cycle from load to valid; backpressure: contents frozen until cleared or reloaded.
module rf_dump_outreg
    import rf_dbg_pkg::*;
#(
    parameter int W = $bits(beat_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         vld,
    output logic [W-1:0] dat
);

    // load wins over clear so a handshake can be followed by a new beat in the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (load) begin
            vld <= 1'b1;
            dat <= din;
        end else if (clear) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_dump_reader.sv
// Walks a register-file address range and streams each word out; RF_DUMP_CHECKSUM_EN adds an XOR beat.
// Latency: first word valid 2 edges after start, at most one word per 2 cycles.
// Backpressure: beat and read address held stable while out_ready is low.
module rf_dump_reader
    import rf_dbg_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    rf_dump_reader_if.master bus
);

    localparam int BW = DATA_W + ADDR_W + 1;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] last_q;
    logic              busy_q;
    logic              done_q;
    logic              accept;
    logic              advance;
    logic              load;
    logic              clear;
    logic              hs;
    logic              at_end;
    logic [BW-1:0]     beat_d;
    logic [BW-1:0]     beat_q;
`ifdef RF_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] xsum;
`endif

    assign hs     = bus.out_valid & bus.out_ready;
    assign at_end = (cur == last_q);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        advance = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
        beat_d  = {bus.rf_dout, cur, 1'b0};
`else
        beat_d  = {bus.rf_dout, cur, at_end};
`endif
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_n = READ;
                end
            end
            READ: begin
                load    = 1'b1;
                state_n = SEND;
            end
            SEND: begin
                if (hs) begin
                    clear = 1'b1;
                    if (at_end) begin
`ifdef RF_DUMP_CHECKSUM_EN
                        load    = 1'b1;
                        beat_d  = {xsum, {ADDR_W{1'b0}}, 1'b1};
                        state_n = SUM;
`else
                        state_n = DONE;
`endif
                    end else begin
                        advance = 1'b1;
                        state_n = READ;
                    end
                end
            end
            SUM: begin
                if (hs) begin
                    clear   = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // abort overrides every transition, including a start seen in IDLE
        if (bus.abort) begin
            state_n = IDLE;
            accept  = 1'b0;
            advance = 1'b0;
            load    = 1'b0;
            clear   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cur    <= '0;
            last_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= (state == DONE) && !bus.abort;
            if (accept) begin
                cur    <= bus.first_addr;
                last_q <= bus.last_addr;
                busy_q <= 1'b1;
            end else if (advance) begin
                cur <= cur + 1'b1;
            end
            if (bus.abort || state == DONE) begin
                busy_q <= 1'b0;
            end
        end
    end

`ifdef RF_DUMP_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            xsum <= '0;
        end else if (state == READ && !bus.abort) begin
            xsum <= xsum ^ bus.rf_dout;
        end
    end

    assign bus.sum_beat = (state == SUM);
`endif

    rf_dump_outreg #(.W(BW)) u_outreg (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .clear (clear),
        .din   (beat_d),
        .vld   (bus.out_valid),
        .dat   (beat_q)
    );

    assign {bus.out_data, bus.out_idx, bus.out_last} = beat_q;
    assign bus.rf_addr = (state == IDLE) ? '0 : cur;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: register-file model, randomized ranges/stalls, range-walk reference model.
// Drives inputs on negedge, samples outputs on negedge.
module tb_rf_dump_reader;
    import rf_dbg_pkg::*;

    typedef struct {
        logic [4:0] idx;
        bit         is_sum;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rf_dump_reader_if bus ();

    rf_dump_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // register file model with write-first debug read port
    logic [31:0] regs [32];
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    assign bus.rf_dout = (wr_en && wr_addr == bus.rf_addr) ? wr_data : regs[bus.rf_addr];

    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int stall_pct,
                            input int stall_idx, input bit glitch, input bit bypass);
        exp_t        exp_q[$];
        exp_t        e;
        logic [4:0]  a;
        logic [31:0] xs;
        logic [31:0] ed;
        logic        el;
        beat_t       prev;
        logic [4:0]  prev_addr;
        bit          hold, finished, gap_chk, wrote;
        int          c, hs_c, stalls;
        a = f;
        forever begin
            exp_q.push_back('{a, 1'b0});
            if (a == l) break;
            a = a + 5'd1;
        end
`ifdef RF_DUMP_CHECKSUM_EN
        exp_q.push_back('{5'd0, 1'b1});
`endif
        xs = 0; hold = 0; finished = 0; gap_chk = 0; wrote = 0;
        hs_c = -10; stalls = 0; c = 0; prev = '0; prev_addr = '0;
        bus.first_addr = f; bus.last_addr = l; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.out_valid} !== 2'b10)
            $display("FAIL start_accept: busy/valid=%b required 10", {bus.busy, bus.out_valid});
        if ({bus.busy, bus.out_valid} !== 2'b10) errors++;
        while (!finished && c < 600) begin
            if (wr_en) begin
                regs[wr_addr] = wr_data;
                wr_en = 1'b0;
            end
            if (bypass && !wrote && bus.busy && !bus.out_valid && bus.rf_addr == 5'd4) begin
                wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hDEADBEEF; wrote = 1;
            end
            bus.start = (glitch && c == 2);
            if (glitch && c == 2) begin
                bus.first_addr = 5'($urandom);
                bus.last_addr  = 5'($urandom);
            end
            if (c == 1) begin
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL first_latency: out_valid=%b required 1", bus.out_valid);
                end
            end
            if (gap_chk && c == hs_c + 1) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gap: out_valid=%b required 0 one cycle after handshake", bus.out_valid);
                end
            end
            if (exp_q.size() != 0 && gap_chk && c == hs_c + 2) begin
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL next_beat: out_valid=%b required 1 two cycles after handshake", bus.out_valid);
                end
            end
            checks++;
            if (exp_q.size() == 0 && c == hs_c + 2) begin
                finished = 1;
                if ({bus.done, bus.busy} !== 2'b10) begin
                    errors++;
                    $display("FAIL done_pulse: done/busy=%b required 10", {bus.done, bus.busy});
                end
            end else if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL stray_done: done=%b required 0 at cycle %0d", bus.done, c);
            end
            if (hold) begin
                checks++;
                if ({bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, bus.rf_addr} !== {1'b1, prev, prev_addr}) begin
                    errors++;
                    $display("FAIL hold: got %h/%0d/%b addr %0d required %h/%0d/%b addr %0d",
                             bus.out_data, bus.out_idx, bus.out_last, bus.rf_addr,
                             prev.data, prev.idx, prev.last, prev_addr);
                end
            end
            hold = 0;
            if (!finished && bus.out_valid) begin
                if (stall_idx >= 0 && bus.out_idx == stall_idx[4:0] && stalls < 4) begin
                    bus.out_ready = 1'b0;
                    stalls++;
                end else begin
                    bus.out_ready = (int'($urandom_range(99)) >= stall_pct);
                end
                if (bus.out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat: idx=%0d data=%h required no beat", bus.out_idx, bus.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_sum) begin
                            ed = xs; el = 1'b1;
                        end else begin
                            ed = regs[e.idx]; xs = xs ^ ed; el = (exp_q.size() == 0);
                        end
                        if ({bus.out_data, bus.out_idx, bus.out_last} !== {ed, e.idx, el}) begin
                            errors++;
                            $display("FAIL beat: got data=%h idx=%0d last=%b required data=%h idx=%0d last=%b",
                                     bus.out_data, bus.out_idx, bus.out_last, ed, e.idx, el);
                        end
                        if (!e.is_sum) begin
                            checks++;
                            if (bus.rf_addr !== e.idx) begin
                                errors++;
                                $display("FAIL rf_addr: got %0d required %0d", bus.rf_addr, e.idx);
                            end
                        end
`ifdef RF_DUMP_CHECKSUM_EN
                        checks++;
                        if (bus.sum_beat !== e.is_sum) begin
                            errors++;
                            $display("FAIL sum_beat: got %b required %b", bus.sum_beat, e.is_sum);
                        end
`endif
                        hs_c = c;
                        gap_chk = (exp_q.size() == 0) || !exp_q[0].is_sum;
                    end
                end
                prev = {bus.out_data, bus.out_idx, bus.out_last};
                prev_addr = bus.rf_addr;
                hold = !bus.out_ready;
            end else begin
                bus.out_ready = 1'($urandom_range(1));
            end
            @(negedge clk);
            c++;
        end
        bus.start = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL timeout: dump %0d..%0d not done, %0d beats outstanding", f, l, exp_q.size());
        end
        checks++;
        if ({bus.done, bus.busy, bus.out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL after_done: done/busy/valid=%b required 000", {bus.done, bus.busy, bus.out_valid});
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, bus.busy, bus.done, bus.rf_addr} !== 46'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h idx=%0d last=%b busy=%b done=%b addr=%0d required all 0",
                     bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, bus.busy, bus.done, bus.rf_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_dump(5'd0, 5'd3, 0, -1, 0, 0);
    endtask

    task automatic test_wrap;
        run_dump(5'd30, 5'd1, 0, -1, 0, 0);
        run_dump(5'd5, 5'd5, 0, -1, 0, 0);
        run_dump(5'd9, 5'd8, 20, -1, 0, 0);
    endtask

    task automatic test_backpressure;
        run_dump(5'd0, 5'd5, 0, 2, 0, 0);
    endtask

    task automatic test_abort;
        bit seen;
        seen = 0;
        bus.first_addr = 5'd0; bus.last_addr = 5'd7; bus.start = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.out_valid && bus.out_idx == 5'd1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_reach: beat idx 1 never presented");
        end
        bus.abort = 1'b1;
        bus.out_ready = 1'($urandom_range(1));
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if ({bus.out_valid, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL abort_stop: valid/busy=%b required 00", {bus.out_valid, bus.busy});
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({bus.out_valid, bus.busy, bus.done} !== 3'b000) begin
                errors++;
                $display("FAIL abort_quiet: valid/busy/done=%b required 000", {bus.out_valid, bus.busy, bus.done});
            end
            @(negedge clk);
        end
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.out_valid, bus.busy} !== 2'b00) begin
                errors++;
                $display("FAIL abort_start: valid/busy=%b required 00", {bus.out_valid, bus.busy});
            end
            @(negedge clk);
        end
        run_dump(5'd0, 5'd7, 25, -1, 1, 0);
    endtask

    task automatic test_bypass;
        run_dump(5'd2, 5'd6, 0, -1, 0, 1);
    endtask

    task automatic test_random;
        logic [4:0] f;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'd0;
        for (int n = 0; n < 6; n++) begin
            f = 5'($urandom);
            run_dump(f, 5'($urandom), 30, -1, 1, 0);
        end
        f = 5'($urandom);
        run_dump(f, f - 5'd1, 10, -1, 0, 0);
    endtask

    task automatic test_reset_mid;
        bus.first_addr = 5'd0; bus.last_addr = 5'd31; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.out_ready = 1'($urandom_range(1));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, bus.busy, bus.done, bus.rf_addr} !== 46'd0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b data=%h idx=%0d last=%b busy=%b done=%b addr=%0d required all 0",
                     bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, bus.busy, bus.done, bus.rf_addr);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.busy, bus.done} !== 3'b000) begin
                errors++;
                $display("FAIL reset_quiet: valid/busy/done=%b required 000", {bus.out_valid, bus.busy, bus.done});
            end
        end
    endtask

`ifdef RF_DUMP_CHECKSUM_EN
    task automatic test_checksum;
        regs[1] = 32'h1; regs[2] = 32'h2; regs[3] = 32'h4;
        run_dump(5'd1, 5'd3, 0, -1, 0, 0);
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
        bus.first_addr = '0; bus.last_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 32; i++) regs[i] = i * 32'h11;
        test_reset;
        test_basic;
        test_wrap;
        test_backpressure;
        test_abort;
        test_bypass;
`ifdef RF_DUMP_CHECKSUM_EN
        test_checksum;
`endif
        test_random;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_dump_reader.md
Name: rf_dump_reader

Overview:
- Initiator on the register file's debug (SDU) read port.
- On command, walks a range of register addresses, samples the read-port data, and streams each word out on a valid/ready channel. The downstream consumer is the SDU transmit path.
- Sits beside the register file in the debug path and never touches the write port.
- The read port is combinational and write-first, so a word sampled in the same cycle as a writeback returns the value being written.

Parameters:
- DATA_W, 32, register word width
- ADDR_W, 5, register address width; 2**ADDR_W registers

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle command pulse; accepted only when busy=0
- abort  in  1  cancels a dump in progress
- first_addr  in  ADDR_W  first register to read, sampled on an accepted start
- last_addr  in  ADDR_W  last register to read, sampled on an accepted start
- rf_addr  out  ADDR_W  drives the register file debug read address
- rf_dout  in  DATA_W  register file debug read data (combinational)
- out_valid  out  1  output word valid
- out_ready  in  1  consumer ready
- out_data  out  DATA_W  captured register value
- out_idx  out  ADDR_W  address the word was read from
- out_last  out  1  marks the final beat of the dump
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse after the final beat completes

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE.
  - rf_addr=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0.
  - Reset mid-dump discards everything and emits no done.
- States: IDLE, READ, SEND, DONE (plus SUM when the optional feature is enabled).
- IDLE:
  - rf_addr=0.
  - start=1 latches first_addr into cur and last_addr into end. Next state READ, busy=1.
- READ (1 cycle):
  - rf_addr=cur.
  - At posedge: out_data<=rf_dout, out_idx<=cur, out_last<=(cur==end), out_valid<=1. Next state SEND.
- SEND:
  - rf_addr holds cur.
  - out_data, out_idx and out_last stay stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready:
    - If cur==end: out_valid<=0, next state DONE.
    - Otherwise: cur<=cur+1 (mod 2**ADDR_W), out_valid<=0, next state READ.
- DONE (1 cycle): done=1, busy<=0, next state IDLE.
- Latency and throughput:
  - Start accepted at edge N → rf_addr=first during cycle N+1 → out_valid=1 from edge N+2.
  - Maximum rate is one word per 2 cycles.
- Range rules:
  - first==last produces exactly 1 beat.
  - first>last wraps through 2**ADDR_W-1 to 0. Example: first=30, last=1 gives idx 30, 31, 0, 1.
  - The full range is expressed as first=k, last=k-1 (mod 2**ADDR_W).
- start while busy=1 is ignored and does not change the range.
- abort:
  - Has priority over every transition except rst.
  - Next state IDLE, out_valid<=0, busy<=0, no done, no out_last beat.
  - A handshake in the abort cycle is still counted by the consumer, but no further beats follow.
- start and abort together in IDLE: abort wins and the command is dropped.
- Register 0 is read like any other register (value 0).
- Sampled data reflects the register file's same-cycle write bypass. No extra forwarding happens here.

Optional Feature:
- Macro: RF_DUMP_CHECKSUM_EN.
- Defined:
  - A running XOR of every captured word is kept; it is cleared on an accepted start.
  - After the handshake of the range's last word, the next state is SUM instead of DONE. In that last word's beat, out_last=0.
  - SUM presents out_data=XOR, out_idx=0, out_last=1, out_valid=1, and obeys the same hold rules as SEND.
  - After the SUM handshake, next state DONE.
  - Extra output port sum_beat (1 bit) is high only during the SUM beat.
- Undefined: no SUM state and no sum_beat port; behaviour is exactly as above.

Decomposition:
- Shared package (rf_dbg_pkg):
  - Typedef for the state enum: IDLE, READ, SEND, SUM, DONE.
  - Constants RF_ADDR_W=5 and RF_DATA_W=32.
  - Typedef for a beat struct: data, idx, last.
- Sub-module rf_dump_outreg: the valid/ready output holding register (load, hold, clear), reusable by other SDU streamers.
- The FSM and address counter stay in the top module.

Test Plan:
- Reset, then first=0, last=3, out_ready=1, rf_dout=addr*0x11 → beats idx 0..3 with data 0x00, 0x11, 0x22, 0x33. out_last only on idx 3. done pulses once, 2 cycles after the last handshake edge. busy falls together with done.
- first=30, last=1 → idx sequence 30, 31, 0, 1 with no extra beats. first=5, last=5 → exactly 1 beat, out_last=1.
- Backpressure: out_ready low for 4 cycles during the beat for idx 2 → out_data, out_idx and rf_addr are unchanged across the stall, and the next beat appears 2 cycles after the handshake.
- Abort asserted during SEND of idx 1 of a 0..7 dump → out_valid=0 and busy=0 next cycle, no done, no out_last. A fresh start afterwards is accepted and runs normally. start pulsed while busy has no effect.
- Write-bypass: register file writes 0xDEADBEEF to x4 in the same cycle rf_addr=4 → the beat for idx 4 carries 0xDEADBEEF. rst asserted mid-dump → all outputs 0 next cycle.
- RF_DUMP_CHECKSUM_EN defined, range 1..3 with data 0x1, 0x2, 0x4 → three data beats with out_last=0, then a sum beat with data 0x7, idx 0, out_last=1, sum_beat=1, then done.
